// File: rtl/multicycle_control.sv
// Moore sequencer for the multi-cycle MIPS datapath: steps each instruction
// through fetch/decode/execute/memory/writeback and drives every datapath control.
module multicycle_control #(
  parameter int CNT_W         = 32,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             mem_ready,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             zero_ext,
  output logic [2:0]       alu_control,
  output logic [1:0]       pc_src,
  output logic             pc_write,
  output logic             branch,
  output logic             illegal_instr,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retire_count
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB   = 4'd4,  MEMWR  = 4'd5,  RTYPEEX = 4'd6, ALUWB  = 4'd7,
    BEQEX   = 4'd8,  ADDIEX = 4'd9,  IWB    = 4'd10, ORIEX  = 4'd11,
    JEX     = 4'd12
  } state_t;

  // fetch marks the state whose IR/PC writes are qualified by mem_ready
  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       fetch;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       zero_ext;
    logic [2:0] alu_control;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Returns {supported, alu_control} for an R-type funct field.
  function automatic logic [3:0] funct_decode(input logic [5:0] f);
    case (f)
      6'b000000: return {1'b1, 3'b100};
      6'b100000: return {1'b1, 3'b010};
      6'b100010: return {1'b1, 3'b110};
      6'b100100: return {1'b1, 3'b000};
      6'b100101: return {1'b1, 3'b001};
      6'b101011: return {1'b1, 3'b111};
      default:   return {1'b0, 3'b010};
    endcase
  endfunction

  function automatic ctrl_t decode_ctrl(input state_t s, input logic [2:0] rtype_alu);
    ctrl_t c;
    c             = '0;
    c.alu_control = 3'b010;
    case (s)
      FETCH:   begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.fetch = 1'b1; end
      DECODE:  c.alu_src_b = 2'b11;
      MEMADR:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      MEMRD:   begin c.iord = 1'b1; c.mem_read = 1'b1; end
      MEMWB:   begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
      MEMWR:   begin c.iord = 1'b1; c.mem_write = 1'b1; end
      RTYPEEX: begin c.alu_src_a = 1'b1; c.alu_control = rtype_alu; end
      ALUWB:   begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
      BEQEX:   begin
        c.alu_src_a = 1'b1; c.alu_control = 3'b110; c.branch = 1'b1; c.pc_src = 2'b01;
      end
      ADDIEX:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      ORIEX:   begin
        c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.zero_ext = 1'b1; c.alu_control = 3'b001;
      end
      IWB:     c.reg_write = 1'b1;
      JEX:     begin c.pc_src = 2'b10; c.pc_write = 1'b1; end
      default: c.alu_control = 3'b010;
    endcase
    return c;
  endfunction

  state_t           state_r;
  state_t           next_s;
  ctrl_t            ctrl_r;
  logic [3:0]       funct_dec_s;
  logic             ready_s;
  logic             illegal_s;
  logic             retire_s;
  logic [CNT_W-1:0] count_r;

  assign ready_s     = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign funct_dec_s = funct_decode(funct);

  // Next-state selection, illegal-instruction detection and retirement strobe.
  always_comb begin
    next_s    = FETCH;
    illegal_s = 1'b0;
    retire_s  = 1'b0;
    case (state_r)
      FETCH:   if (ready_s) next_s = DECODE; else next_s = FETCH;
      DECODE: begin
        case (op)
          OP_RTYPE:     next_s = RTYPEEX;
          OP_LW, OP_SW: next_s = MEMADR;
          OP_BEQ:       next_s = BEQEX;
          OP_ADDI:      next_s = ADDIEX;
          OP_ORI:       next_s = ORIEX;
          OP_J:         next_s = JEX;
          default: begin
            next_s    = FETCH;
            illegal_s = 1'b1;
          end
        endcase
      end
      MEMADR:  if (op == OP_LW) next_s = MEMRD; else next_s = MEMWR;
      MEMRD:   if (ready_s) next_s = MEMWB; else next_s = MEMRD;
      MEMWB:   begin next_s = FETCH; retire_s = 1'b1; end
      MEMWR: begin
        if (ready_s) begin
          next_s   = FETCH;
          retire_s = 1'b1;
        end else begin
          next_s   = MEMWR;
        end
      end
      RTYPEEX: begin
        if (funct_dec_s[3]) begin
          next_s    = ALUWB;
        end else begin
          next_s    = FETCH;
          illegal_s = 1'b1;
        end
      end
      ALUWB:   begin next_s = FETCH; retire_s = 1'b1; end
      BEQEX:   begin next_s = FETCH; retire_s = 1'b1; end
      ADDIEX:  next_s = IWB;
      ORIEX:   next_s = IWB;
      IWB:     begin next_s = FETCH; retire_s = 1'b1; end
      JEX:     begin next_s = FETCH; retire_s = 1'b1; end
      default: next_s = FETCH;
    endcase
  end

  // State, retire counter and control word decoded ahead from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= FETCH;
      ctrl_r  <= decode_ctrl(FETCH, 3'b010);
      count_r <= '0;
    end else begin
      state_r <= next_s;
      ctrl_r  <= decode_ctrl(next_s, funct_dec_s[2:0]);
      if (retire_s) begin
        count_r <= count_r + CNT_W'(1);
      end else begin
        count_r <= count_r;
      end
    end
  end

  // Strobes are gated by reset so nothing fires while it is held.
  assign iord          = ctrl_r.iord;
  assign mem_read      = ctrl_r.mem_read & ~reset;
  assign mem_write     = ctrl_r.mem_write & ~reset;
  assign ir_write      = ctrl_r.fetch & ready_s & ~reset;
  assign reg_dst       = ctrl_r.reg_dst;
  assign mem_to_reg    = ctrl_r.mem_to_reg;
  assign reg_write     = ctrl_r.reg_write & ~reset;
  assign alu_src_a     = ctrl_r.alu_src_a;
  assign alu_src_b     = ctrl_r.alu_src_b;
  assign zero_ext      = ctrl_r.zero_ext;
  assign alu_control   = ctrl_r.alu_control;
  assign pc_src        = ctrl_r.pc_src;
  assign pc_write      = (ctrl_r.pc_write | (ctrl_r.fetch & ready_s)) & ~reset;
  assign branch        = ctrl_r.branch & ~reset;
  assign illegal_instr = illegal_s & ~reset;
  assign state         = state_r;
  assign retire_count  = count_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed cases then randomized
// instructions checked cycle by cycle against a path/output reference model.
module tb_multicycle_control;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [5:0]       op;
  logic [5:0]       funct;
  logic             mem_ready;
  logic             iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic             alu_src_a, zero_ext, pc_write, branch, illegal_instr;
  logic [1:0]       alu_src_b, pc_src;
  logic [2:0]       alu_control;
  logic [3:0]       state;
  logic [CNT_W-1:0] retire_count;
  logic [18:0]      obs_out;

  int               total    = 0;
  int               pass_cnt = 0;
  int               fail_cnt = 0;
  logic [CNT_W-1:0] exp_cnt;
  int               sq[$];
  logic             rq[$];

  logic [5:0] good_f [6] = '{6'b000000, 6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101011};
  logic [5:0] bad_f  [4] = '{6'b000001, 6'b111111, 6'b100001, 6'b101010};
  logic [5:0] bad_op [4] = '{6'b111111, 6'b000001, 6'b000101, 6'b001111};

  always #5 clk = ~clk;

  multicycle_control #(.CNT_W(CNT_W), .MEM_HANDSHAKE(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .mem_ready(mem_ready),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .zero_ext(zero_ext),
    .alu_control(alu_control), .pc_src(pc_src), .pc_write(pc_write), .branch(branch),
    .illegal_instr(illegal_instr), .state(state), .retire_count(retire_count)
  );

  assign obs_out = {iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                    alu_src_a, alu_src_b, zero_ext, alu_control, pc_src, pc_write, branch,
                    illegal_instr};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit funct_ok(input logic [5:0] f);
    return f inside {6'b000000, 6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101011};
  endfunction

  function automatic bit op_ok(input logic [5:0] o);
    return o inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b001101, 6'b000010};
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b000000: return 3'b100;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101011: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Expected output bundle for a state, straight from the per-state output table.
  function automatic logic [18:0] exp_out(input int s, input logic rdy,
                                          input logic [5:0] o, input logic [5:0] f);
    logic io, mr, mw, irw, rd, mtr, rw, sa, ze, pcw, br, ill;
    logic [1:0] sb, pcs;
    logic [2:0] alu;
    {io, mr, mw, irw, rd, mtr, rw, sa, ze, pcw, br, ill} = 12'b0;
    sb = 2'b00; pcs = 2'b00; alu = 3'b010;
    case (s)
      0:  begin mr = 1'b1; sb = 2'b01; irw = rdy; pcw = rdy; end
      1:  begin sb = 2'b11; ill = !op_ok(o); end
      2:  begin sa = 1'b1; sb = 2'b10; end
      3:  begin io = 1'b1; mr = 1'b1; end
      4:  begin mtr = 1'b1; rw = 1'b1; end
      5:  begin io = 1'b1; mw = 1'b1; end
      6:  begin sa = 1'b1; alu = funct_alu(f); ill = !funct_ok(f); end
      7:  begin rd = 1'b1; rw = 1'b1; end
      8:  begin sa = 1'b1; alu = 3'b110; br = 1'b1; pcs = 2'b01; end
      9:  begin sa = 1'b1; sb = 2'b10; end
      10: rw = 1'b1;
      11: begin sa = 1'b1; sb = 2'b10; ze = 1'b1; alu = 3'b001; end
      12: begin pcs = 2'b10; pcw = 1'b1; end
      default: ill = 1'b0;
    endcase
    return {io, mr, mw, irw, rd, mtr, rw, sa, sb, ze, alu, pcs, pcw, br, ill};
  endfunction

  task automatic push(input int s, input logic r);
    sq.push_back(s);
    rq.push_back(r);
  endtask

  task automatic cycle(input int s, input logic r, input string tag);
    mem_ready = r;
    @(negedge clk);
    chk({tag, "_state"}, {28'b0, state}, s);
    chk({tag, "_outs"}, {13'b0, obs_out}, {13'b0, exp_out(s, r, op, funct)});
    @(posedge clk);
    #1;
  endtask

  // Builds the expected state path of one instruction and walks it cycle by cycle.
  task automatic run_instr(input string tag, input logic [5:0] o, input logic [5:0] f,
                           input int wf, input int wm);
    bit retires;
    sq.delete();
    rq.delete();
    op = o;
    funct = f;
    repeat (wf) push(0, 1'b0);
    push(0, 1'b1);
    push(1, 1'b1);
    retires = 1'b1;
    case (o)
      6'b000000: if (funct_ok(f)) begin push(6, 1'b1); push(7, 1'b1); end
                 else begin push(6, 1'b1); retires = 1'b0; end
      6'b100011: begin
        push(2, 1'b1);
        repeat (wm) push(3, 1'b0);
        push(3, 1'b1);
        push(4, 1'b1);
      end
      6'b101011: begin
        push(2, 1'b1);
        repeat (wm) push(5, 1'b0);
        push(5, 1'b1);
      end
      6'b000100: push(8, 1'b1);
      6'b001000: begin push(9, 1'b1); push(10, 1'b1); end
      6'b001101: begin push(11, 1'b1); push(10, 1'b1); end
      6'b000010: push(12, 1'b1);
      default:   retires = 1'b0;
    endcase
    for (int i = 0; i < sq.size(); i++) cycle(sq[i], rq[i], tag);
    if (retires) exp_cnt = exp_cnt + 1'b1;
    chk({tag, "_retire"}, {28'b0, retire_count}, {28'b0, exp_cnt});
  endtask

  initial begin
    logic [5:0] o, f;
    reset = 1'b1; mem_ready = 1'b1; op = 6'b000000; funct = 6'b100000;
    exp_cnt = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", {28'b0, state}, 32'd0);
    chk("rst_count", {28'b0, retire_count}, 32'd0);
    chk("rst_strobes", {25'b0, mem_read, mem_write, ir_write, reg_write, pc_write, branch,
                        illegal_instr}, 32'd0);
    reset = 1'b0;

    run_instr("radd", 6'b000000, 6'b100000, 0, 0);
    run_instr("lw_wait", 6'b100011, 6'b000000, 0, 2);
    run_instr("beq", 6'b000100, 6'b010101, 0, 0);
    run_instr("sw", 6'b101011, 6'b000000, 0, 0);
    run_instr("ori", 6'b001101, 6'b000000, 0, 0);
    run_instr("j", 6'b000010, 6'b000000, 0, 0);
    run_instr("bad_op", 6'b111111, 6'b000000, 0, 0);
    run_instr("bad_funct", 6'b000000, 6'b111111, 0, 0);
    run_instr("fetch_wait", 6'b001000, 6'b000000, 2, 0);

    for (int n = 0; n < 40; n++) begin
      f = 6'($urandom);
      case ($urandom_range(0, 8))
        0: begin o = 6'b000000; f = good_f[$urandom_range(0, 5)]; end
        1: begin o = 6'b000000; f = bad_f[$urandom_range(0, 3)]; end
        2: o = 6'b100011;
        3: o = 6'b101011;
        4: o = 6'b000100;
        5: o = 6'b001000;
        6: o = 6'b001101;
        7: o = 6'b000010;
        default: o = bad_op[$urandom_range(0, 3)];
      endcase
      run_instr("rand", o, f, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    // Reset while a load waits in MEMRD: no writeback may follow.
    op = 6'b100011; funct = 6'b000000;
    cycle(0, 1'b1, "rmid");
    cycle(1, 1'b1, "rmid");
    cycle(2, 1'b1, "rmid");
    mem_ready = 1'b0;
    @(negedge clk);
    chk("rmid_in_memrd", {28'b0, state}, 32'd3);
    reset = 1'b1;
    #1;
    chk("rmid_strobes", {25'b0, mem_read, mem_write, ir_write, reg_write, pc_write, branch,
                         illegal_instr}, 32'd0);
    @(posedge clk);
    #1;
    chk("rmid_state", {28'b0, state}, 32'd0);
    chk("rmid_count", {28'b0, retire_count}, 32'd0);
    exp_cnt = '0;
    reset = 1'b0;
    mem_ready = 1'b1;

    for (int n = 0; n < 16; n++) run_instr("wrap", 6'b001000, 6'b000000, 0, 0);
    chk("wrap_zero", {28'b0, retire_count}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
